// File: rtl/swin_pkg.sv
// Shared defaults for the streaming-window block family.
package swin_pkg;

  localparam int SWIN_DATA_WIDTH = 8;
  localparam int SWIN_ADDR_WIDTH = 4;
  localparam int SWIN_DEPTH      = 1 << SWIN_ADDR_WIDTH;

endpackage : swin_pkg

// File: rtl/dbram.sv
// Distributed dual-address RAM: synchronous write port, registered read port
// that reloads from rd_addr on every rising edge (1-cycle read latency).
// A read and a write to the same address on the same edge return the old word.
module dbram
  import swin_pkg::*;
#(
  parameter int DATA_WIDTH = SWIN_DATA_WIDTH,
  parameter int ADDR_WIDTH = SWIN_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage array: no reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Asynchronous array lookup feeding the read register.
  always_comb begin
    rd_data_d = mem_q[rd_addr];
  end

  // Read output register; cleared by reset so the FIFO head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule : dbram

// File: rtl/dbram_fifo.sv
// Single-clock valid/ready FIFO built on one dbram instance.
// The head word comes straight from the RAM read register; the read address
// is steered one entry ahead on a pop so the next head is ready one edge later.
module dbram_fifo
  import swin_pkg::*;
#(
  parameter int DATA_WIDTH = SWIN_DATA_WIDTH,
  parameter int DEPTH      = SWIN_DEPTH,
  parameter int ADDR_WIDTH = SWIN_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int                    CW         = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         FULL_COUNT = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CW-1:0]         count_d, count_q;
  logic                  out_valid_d, out_valid_q;
  logic                  in_ready_d, in_ready_q;

  // Handshakes and pointer advance; pointers wrap naturally since DEPTH is 2**ADDR_WIDTH.
  always_comb begin
    push     = in_valid && in_ready_q;
    pop      = out_valid_q && out_ready;
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    // Look ahead to the following entry when the head is consumed this cycle.
    rd_addr  = rd_ptr_d;
  end

  // Occupancy and registered flags. A word written this cycle is excluded from
  // out_valid because the RAM read register cannot see it until the next edge.
  always_comb begin
    count_d     = count_q + CW'(push) - CW'(pop);
    out_valid_d = (count_q - CW'(pop)) != '0;
    in_ready_d  = (count_d != FULL_COUNT);
  end

  // Control state; everything clears asynchronously, in_ready rises on the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  dbram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (out_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule : dbram_fifo

// File: tb/tb_dbram_fifo.sv
// Bench for dbram_fifo: vector table, directed corner sequences, and a
// randomized run against a queue-based reference model.
module tb_dbram_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW:0]   count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dbram_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  typedef struct {
    logic          iv;
    logic [7:0]    id;
    logic          ordy;
    logic          ev;
    logic          chk_d;
    logic [7:0]    ed;
    logic [4:0]    ec;
    logic          er;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    step();
    chk("rst_first_edge_in_ready", in_ready, 1);
  endtask

  // Three pushes with consumer stalled, then drain.
  task automatic run_table();
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b1};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 5'd2, 1'b1};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 5'd3, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 5'd3, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 5'd2, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 5'd1, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      step();
      chk($sformatf("tbl%0d_out_valid", i), out_valid, vecs[i].ev);
      chk($sformatf("tbl%0d_count", i), count, vecs[i].ec);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, vecs[i].er);
      if (vecs[i].chk_d) chk($sformatf("tbl%0d_out_data", i), out_data, vecs[i].ed);
    end
    out_ready = 1'b0;
  endtask

  // Fill to full, offer a 17th word, pop once, drain in order.
  task automatic run_full();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
    end
    chk("full_count", count, 16);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    in_data = 8'hEE;
    step();
    chk("full_ignored_count", count, 16);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("full_head", out_data, 8'h00);
    step();
    chk("full_pop_in_ready", in_ready, 1);
    chk("full_pop_count", count, 15);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("full_drain_valid%0d", i), out_valid, 1);
      chk($sformatf("full_drain_data%0d", i), out_data, 8'(i));
      step();
    end
    out_ready = 1'b0;
    chk("full_drained_count", count, 0);
    chk("full_drained_valid", out_valid, 0);
  endtask

  // Steady one-in/one-out at count 5 across several pointer wraps.
  task automatic run_stream();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h40 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("stream_pre_count", count, 5);
    for (int i = 0; i < 40; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'(8'h45 + i);
      out_ready = 1'b1;
      chk($sformatf("stream_valid%0d", i), out_valid, 1);
      chk($sformatf("stream_data%0d", i), out_data, 8'(8'h40 + i));
      step();
      chk($sformatf("stream_count%0d", i), count, 5);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stream_tail_valid%0d", k), out_valid, 1);
      chk($sformatf("stream_tail_data%0d", k), out_data, 8'(8'h68 + k));
      step();
    end
    out_ready = 1'b0;
    chk("stream_end_count", count, 0);
    chk("stream_end_valid", out_valid, 0);
  endtask

  // Single entry through an always-ready consumer.
  task automatic run_single();
    int pops;
    pops      = 0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        pops++;
        chk("single_data", out_data, 8'hA5);
      end
      step();
    end
    out_ready = 1'b0;
    chk("single_pops", pops, 1);
    chk("single_out_valid", out_valid, 0);
    chk("single_count", count, 0);
  endtask

  // Asynchronous reset with data in flight, then recovery.
  task automatic run_midreset();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h90 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("mid_count", count, 9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_data", out_data, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rel_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 8'h7E;
    step();
    in_valid = 1'b0;
    chk("mid_push_count", count, 1);
    step();
    chk("mid_readback_valid", out_valid, 1);
    chk("mid_readback_data", out_data, 8'h7E);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("mid_final_count", count, 0);
  endtask

  // Random traffic against a queue model of the FIFO contents.
  task automatic run_random();
    logic [7:0] mq[$];
    logic       m_vld;
    logic       m_rdy;
    logic       push;
    logic       pop;
    int         old_size;
    m_vld = 1'b0;
    m_rdy = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      push = in_valid && m_rdy;
      pop  = m_vld && out_ready;
      if (m_vld) chk("rand_data", out_data, mq[0]);
      old_size = mq.size();
      step();
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(in_data);
      // Head is presentable only if it was stored before this edge.
      m_vld = (old_size - int'(pop)) != 0;
      m_rdy = mq.size() != DEPTH;
      chk("rand_count", count, mq.size());
      chk("rand_out_valid", out_valid, m_vld);
      chk("rand_in_ready", in_ready, m_rdy);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    do_reset();
    run_table();
    run_full();
    run_stream();
    run_single();
    run_midreset();
    do_reset();
    run_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_dbram_fifo

// File: doc/dbram_fifo.md
DBRAM_FIFO -- requirements
Module: dbram_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 Parameter DEPTH, default 16, storage entries; SHALL equal 2**ADDR_WIDTH.
REQ-003 Parameter ADDR_WIDTH, default 4, RAM address width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  DATA_WIDTH  write payload.
REQ-007 in_valid  input  1  producer offers in_data.
REQ-008 in_ready  output  1  FIFO can accept; push = in_valid && in_ready.
REQ-009 out_data  output  DATA_WIDTH  head entry, driven from the RAM registered read port.
REQ-010 out_valid  output  1  out_data holds a valid head entry.
REQ-011 out_ready  input  1  consumer accepts; pop = out_valid && out_ready.
REQ-012 count  output  ADDR_WIDTH+1  entries currently stored, 0..DEPTH.

Function
REQ-013 Storage SHALL be one dual-address RAM: synchronous write port (data, addr, enable) and a read port whose output register updates every cycle from rd_addr, with 1-cycle latency.
REQ-014 On push, in_data SHALL be written at wr_ptr; wr_ptr SHALL increment modulo DEPTH.
REQ-015 On pop, rd_ptr SHALL increment modulo DEPTH.
REQ-016 RAM rd_addr SHALL be driven combinationally: rd_ptr+1 (mod DEPTH) when pop, else rd_ptr.
REQ-017 count_next = count + push - pop; simultaneous push and pop SHALL leave count unchanged.
REQ-018 out_valid_next SHALL be ((count - pop) != 0); the entry written in the current cycle SHALL NOT count.
REQ-019 Write-to-out_valid latency SHALL be 2 cycles: push at edge T gives out_valid high after edge T+1 when the FIFO was empty.
REQ-020 in_ready SHALL be a register with in_ready_next = (count_next != DEPTH).
REQ-021 At full (count == DEPTH), in_ready SHALL be 0 and in_valid SHALL be ignored; a pop at full SHALL raise in_ready on the next cycle.
REQ-022 At empty, out_valid SHALL be 0 and out_ready SHALL be ignored.
REQ-023 out_data SHALL be stable while out_valid && !out_ready.
REQ-024 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no bubble and no data loss.
REQ-025 Sustained push and pop at 1 per cycle SHALL be supported whenever 0 < count < DEPTH.
REQ-026 Data order SHALL be strictly first-in first-out, with no duplication or drop.

Reset
REQ-027 While rst_n is low: wr_ptr = 0, rd_ptr = 0, count = 0, out_valid = 0, in_ready = 0, out_data = 0.
REQ-028 The first rising edge after rst_n deasserts SHALL set in_ready to 1.
REQ-029 Reset mid-operation SHALL discard all stored entries immediately; RAM contents need not be cleared.

Structure
REQ-030 Defaults for DATA_WIDTH, DEPTH and ADDR_WIDTH SHALL live in the shared package swin_pkg.
REQ-031 Storage SHALL be the team's existing distributed-RAM sub-module dbram, instantiated once.
REQ-032 Pointer, count and handshake logic SHALL be local to dbram_fifo, with no further sub-modules.

Verification
REQ-033 Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=0 -> out_valid rises 2 cycles after the first push; out_data=0x11 holds; count=3.
REQ-034 Push 16 entries 0x00..0x0F with no pop -> in_ready=0 and count=16; a 17th in_valid is ignored; one pop -> in_ready=1 on the next cycle.
REQ-035 With count=5, push and pop every cycle for 40 cycles -> count stays 5, output sequence is in-order, pointers wrap at least twice.
REQ-036 Push a single entry 0xA5 into an empty FIFO with out_ready held high -> exactly one pop of 0xA5, then out_valid=0 and count=0.
REQ-037 Assert rst_n low with count=9 mid-stream -> out_valid=0, count=0 immediately; after release, a push of 0x7E is read back as 0x7E.
REQ-038 Random in_valid/out_ready at 50% for 10000 cycles against a reference queue model -> no mismatch, count always matches the model.
